// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline-stage register for the 5-stage ARM pipeline.
// Carries a payload with per-byte write lanes and a valid bit. Stall holds
// the contents and flush turns them into a bubble. A saturating stall-age
// counter reports how long the current valid payload has been held.

module pipe_stage_reg #(
    parameter int               WIDTH     = 64,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               CNT_W     = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WIDTH-1:0]   dataIn,
    input  logic               validIn,
    input  logic [WIDTH/8-1:0] byteEn,
    input  logic               stall,
    input  logic               flush,
    output logic [WIDTH-1:0]   dataOut,
    output logic               validOut,
    output logic [CNT_W-1:0]   stallCnt
);

    localparam int               NUM_BYTES = WIDTH / 8;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic [CNT_W-1:0] r_stallCnt;
    logic [WIDTH-1:0] w_mergedData;
    logic [CNT_W-1:0] w_stallCntInc;

    // Merge the enabled incoming byte lanes over the currently held payload
    always_comb begin
        w_mergedData = r_data;
        for (int k = 0; k < NUM_BYTES; k++) begin
            if (byteEn[k]) begin
                w_mergedData[k*8 +: 8] = dataIn[k*8 +: 8];
            end
        end
    end

    // The age counter advances only while a real instruction is held, and it stops at max
    always_comb begin
        w_stallCntInc = r_stallCnt;
        if (r_valid && (r_stallCnt != CNT_MAX)) begin
            w_stallCntInc = r_stallCnt + CNT_ONE;
        end
    end

    // Stage register: reset dominates, then flush beats stall, and stall beats load
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data     <= RESET_VAL;
            r_valid    <= 1'b0;
            r_stallCnt <= '0;
        end else if (flush) begin
            r_data     <= RESET_VAL;
            r_valid    <= 1'b0;
            r_stallCnt <= '0;
        end else if (stall) begin
            r_stallCnt <= w_stallCntInc;
        end else begin
            r_data     <= w_mergedData;
            r_valid    <= validIn;
            r_stallCnt <= '0;
        end
    end

    assign dataOut  = r_data;
    assign validOut = r_valid;
    assign stallCnt = r_stallCnt;

endmodule
